// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction prefetcher with redirect flush and registered decoder handshake
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] code,
    output logic [31:0] code_pc,
    output logic        code_valid,
    input  logic        code_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               imem_req_q, imem_req_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        code_q, code_d;
    logic [31:0]        code_pc_q, code_pc_d;
    logic               code_valid_q, code_valid_d;
    logic [63:0]        mem_q [FIFO_DEPTH];

    logic               granted;
    logic               push;
    logic               pop;
    logic [31:0]        req_pc;
    logic [CNT_W-1:0]   remaining;
    logic [63:0]        head_word;

    assign granted = imem_req_q & imem_gnt;
    assign push    = (state_q == S_WAIT) & imem_rvalid & ~redirect;
    assign pop     = code_valid_q & code_ready & ~redirect;
    // fetch_pc was advanced on grant, so the outstanding request is one word behind it
    assign req_pc  = fetch_pc_q - 32'd4;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            S_REQ: begin
                if (granted) begin
                    state_d = redirect ? S_DISCARD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end else if ((state_q == S_REQ) && granted) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
        end
    end

    // The head register is loaded with next cycle's oldest word; a push into an
    // otherwise drained FIFO bypasses storage so it is visible one cycle later.
    always_comb begin
        remaining = count_q - CNT_W'(pop);
        if (remaining == '0) begin
            head_word = {imem_rdata, req_pc};
        end else begin
            head_word = mem_q[rd_ptr_d];
        end
        code_valid_d = (count_d != '0);
        code_d       = code_q;
        code_pc_d    = code_pc_q;
        if (code_valid_d) begin
            code_d    = head_word[63:32];
            code_pc_d = head_word[31:0];
        end
        imem_req_d = (state_d == S_REQ) && (count_d < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            imem_req_q   <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            code_q       <= '0;
            code_pc_q    <= '0;
            code_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            imem_req_q   <= imem_req_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            code_q       <= code_d;
            code_pc_q    <= code_pc_d;
            code_valid_q <= code_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {imem_rdata, req_pc};
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = fetch_pc_q;
    assign code       = code_q;
    assign code_pc    = code_pc_q;
    assign code_valid = code_valid_q;

endmodule
